// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle, result {remainder, quotient}.
// Ready WIDTH+1 edges after start (2 for a zero divisor). Optional DIV_ZERO_TRAP_EN adds the div_zero_o pulse.
module div_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic                 annul_i,
   input  logic [WIDTH-1:0]     dividend_i,
   input  logic [WIDTH-1:0]     divisor_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   result_o
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic                 div_zero_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   dvd;   // shifts dividend bits out the top, quotient bits in the bottom
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH:0]     rem;
   logic               neg_q;
   logic               neg_r;

   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic               q_bit;
   logic [WIDTH-1:0]   quo_nxt;
   logic [WIDTH-1:0]   rem_nxt;
   logic [WIDTH-1:0]   dvd_abs;
   logic [WIDTH-1:0]   dvs_abs;

   assign rem_sh  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
   assign diff    = rem_sh - {1'b0, dvs};
   assign q_bit   = ~diff[WIDTH];
   assign quo_nxt = {dvd[WIDTH-2:0], q_bit};
   assign rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

   assign dvd_abs = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
   assign dvs_abs = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

   assign busy_o  = (state == S_BYZERO) || (state == S_ON);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= '0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_o <= 1'b0;
`endif
      end else begin
`ifdef DIV_ZERO_TRAP_EN
         div_zero_o <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (start_i && !annul_i) begin
                  neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                  neg_r <= signed_i & dividend_i[WIDTH-1];
                  if (divisor_i == '0) begin
                     state <= S_BYZERO;
                  end else begin
                     dvd   <= dvd_abs;
                     dvs   <= dvs_abs;
                     rem   <= '0;
                     cnt   <= '0;
                     state <= S_ON;
                  end
               end
            end
            S_BYZERO: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  state    <= S_END;
                  ready_o  <= 1'b1;
                  result_o <= '0;
`ifdef DIV_ZERO_TRAP_EN
                  div_zero_o <= 1'b1;
`endif
               end
            end
            S_ON: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  dvd <= quo_nxt;
                  rem <= q_bit ? diff : rem_sh;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     // sign fix-up folded into the final step so result and ready land together
                     state    <= S_END;
                     ready_o  <= 1'b1;
                     result_o <= {neg_r ? -rem_nxt : rem_nxt, neg_q ? -quo_nxt : quo_nxt};
                  end
               end
            end
            S_END: begin
               if (annul_i || !start_i) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: vector table plus hand-written annul/reset sequences, scoreboard queue for results.
module tb_div_seq_ctrl;
   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic            signed_i;
   logic            annul_i;
   logic [W-1:0]    dividend_i;
   logic [W-1:0]    divisor_i;
   logic            busy_o;
   logic            ready_o;
   logic [2*W-1:0]  result_o;
`ifdef DIV_ZERO_TRAP_EN
   logic            div_zero_o;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] sb[$];

   typedef struct {
      logic          s;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [2*W-1:0] exp_res;
   } vec_t;

   vec_t tbl[12];

   div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .annul_i    (annul_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .result_o   (result_o)
`ifdef DIV_ZERO_TRAP_EN
      ,
      .div_zero_o (div_zero_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sd;
      if (b == 32'd0) return 64'd0;
      sa = a;
      sd = b;
      if (s) return {32'(sa % sd), 32'(sa / sd)};
      return {a % b, a / b};
   endfunction

   // Full transaction: launch, time the result, check hold while start stays high, then release.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_res);
      int          edges;
      int          lat;
      logic        busy_ok;
      logic [63:0] e;
      lat = (b == 32'd0) ? 2 : W + 1;
      @(negedge clk);
      start_i    = 1'b1;
      signed_i   = s;
      dividend_i = a;
      divisor_i  = b;
      sb.push_back(exp_res);
      edges   = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) begin
            dividend_i = ~a;
            divisor_i  = b + 32'd3;
            signed_i   = ~s;
         end
         if (!ready_o && !busy_o) busy_ok = 1'b0;
      end while (!ready_o && edges < 100);
      chk("latency", edges, lat);
      chk("busy_while_running", busy_ok, 1);
      chk("busy_at_ready", busy_o, 0);
      chk("ready", ready_o, 1);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
      chk("result", result_o, e);
`ifdef DIV_ZERO_TRAP_EN
      chk("div_zero_pulse", div_zero_o, (b == 32'd0));
`endif
      @(posedge clk);
      #1;
      chk("ready_hold", ready_o, 1);
      chk("result_hold", result_o, e);
`ifdef DIV_ZERO_TRAP_EN
      chk("div_zero_single", div_zero_o, 0);
`endif
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_clear", ready_o, 0);
      chk("result_clear", result_o, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      int          edges;

      tbl[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
      tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
      tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC};
      tbl[3]  = '{1'b0, 32'h12345678,   32'd0,        64'h0};
      tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
      tbl[5]  = '{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF};
      tbl[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      tbl[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
      tbl[8]  = '{1'b0, 32'd5,          32'd10,       64'h00000005_00000000};
      tbl[9]  = '{1'b1, 32'hFFFFFFFF,   32'd0,        64'h0};
      tbl[10] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
      tbl[11] = '{1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2};

      rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
      dividend_i = 32'd100; divisor_i = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy_o, 0);
      chk("reset_ready", ready_o, 0);
      chk("reset_result", result_o, 0);
`ifdef DIV_ZERO_TRAP_EN
      chk("reset_div_zero", div_zero_o, 0);
`endif
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;

      for (int i = 0; i < 12; i++)
         do_div(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp_res);

      for (int i = 0; i < 8; i++) begin
         s = i[0];
         a = $urandom;
         b = $urandom >> $urandom_range(0, 28);
         if (b == 32'd0) b = 32'd1;
         if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
         do_div(s, a, b, ref_div(s, a, b));
      end

      // annul has priority over start in IDLE
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0;
      dividend_i = 32'd50; divisor_i = 32'd3;
      @(posedge clk);
      #1;
      chk("annul_idle_busy", busy_o, 0);
      start_i = 1'b0; annul_i = 1'b0;

      // annul on the 10th ON cycle
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      chk("annul_on_busy_before", busy_o, 1);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("annul_on_busy", busy_o, 0);
      chk("annul_on_ready", ready_o, 0);
      chk("annul_on_result", result_o, 0);
      annul_i = 1'b0;
      do_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);

      // annul in BYZERO
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'h12345678; divisor_i = 32'd0;
      @(posedge clk);
      #1;
      chk("byzero_busy", busy_o, 1);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("annul_byzero_ready", ready_o, 0);
      chk("annul_byzero_result", result_o, 0);
`ifdef DIV_ZERO_TRAP_EN
      chk("annul_byzero_div_zero", div_zero_o, 0);
`endif
      annul_i = 1'b0;

      // annul in END while start is still held
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!ready_o && edges < 100);
      chk("annul_end_reached", ready_o, 1);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk("annul_end_ready", ready_o, 0);
      chk("annul_end_result", result_o, 0);
      start_i = 1'b0; annul_i = 1'b0;

      // reset on the 20th ON cycle, start held through it
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFFFFFF; divisor_i = 32'h10;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_ready", ready_o, 0);
      chk("rst_mid_result", result_o, 0);
      rst = 1'b0;
      do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

      chk("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
